// File: rtl/sram_access_seq.sv
// sram_access_seq: sequences one-shot read/write requests into timed async SRAM strobe cycles
module sram_access_seq #(
  parameter int ADDR_W     = 20,
  parameter int READ_WAIT  = 2,
  parameter int WRITE_WAIT = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_rd_req,
  input  logic              i_wr_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [15:0]       i_wdata,
  input  logic [1:0]        i_byte_en,
  output logic              o_busy,
  output logic              o_done,
  output logic [15:0]       o_rdata,
  output logic              o_dropped,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic              o_sram_ce_n,
  output logic              o_sram_oe_n,
  output logic              o_sram_we_n,
  output logic              o_sram_ub_n,
  output logic              o_sram_lb_n,
  output logic [15:0]       o_sram_dq_out,
  output logic              o_sram_dq_oe,
  input  logic [15:0]       i_sram_dq_in
);
  localparam int MAX_WAIT = (READ_WAIT > WRITE_WAIT) ? READ_WAIT : WRITE_WAIT;
  localparam int CNT_W    = $clog2(MAX_WAIT + 1);
  typedef enum logic [2:0] {S_IDLE, S_RD, S_WR_SETUP, S_WR_PULSE, S_WR_HOLD} state_t;
  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [1:0]        r_be, w_be_nxt;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [15:0]       w_wdata_nxt, w_rdata_nxt;
  logic              w_done_nxt, w_accept;
  assign o_busy = (r_state != S_IDLE);
  // next-state, counter, capture and completion decode; write wins over a simultaneous read
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_be_nxt    = r_be;
    w_addr_nxt  = o_sram_addr;
    w_wdata_nxt = o_sram_dq_out;
    w_rdata_nxt = o_rdata;
    w_done_nxt  = 1'b0;
    w_accept    = (r_state == S_IDLE) && (i_rd_req || i_wr_req);
    case (r_state)
      S_IDLE: begin
        if (i_wr_req) w_state_nxt = S_WR_SETUP;
        else if (i_rd_req) begin
          w_state_nxt = S_RD;
          w_cnt_nxt   = CNT_W'(READ_WAIT - 1);
        end
      end
      S_RD: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_IDLE;
          w_rdata_nxt = i_sram_dq_in;
          w_done_nxt  = 1'b1;
        end else w_cnt_nxt = r_cnt - 1'b1;
      end
      S_WR_SETUP: begin
        w_state_nxt = S_WR_PULSE;
        w_cnt_nxt   = CNT_W'(WRITE_WAIT - 1);
      end
      S_WR_PULSE: begin
        if (r_cnt == '0) w_state_nxt = S_WR_HOLD;
        else w_cnt_nxt = r_cnt - 1'b1;
      end
      S_WR_HOLD: begin
        w_state_nxt = S_IDLE;
        w_done_nxt  = 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_accept) begin
      w_be_nxt    = i_byte_en;
      w_addr_nxt  = i_addr;
      w_wdata_nxt = i_wdata;
    end
  end
  // state plus strobes registered from the next state so the SRAM pins never glitch
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_be          <= '0;
      o_done        <= 1'b0;
      o_dropped     <= 1'b0;
      o_rdata       <= '0;
      o_sram_addr   <= '0;
      o_sram_dq_out <= '0;
      o_sram_ce_n   <= 1'b1;
      o_sram_oe_n   <= 1'b1;
      o_sram_we_n   <= 1'b1;
      o_sram_ub_n   <= 1'b1;
      o_sram_lb_n   <= 1'b1;
      o_sram_dq_oe  <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_be          <= w_be_nxt;
      o_done        <= w_done_nxt;
      o_dropped     <= (r_state != S_IDLE) && (i_rd_req || i_wr_req);
      o_rdata       <= w_rdata_nxt;
      o_sram_addr   <= w_addr_nxt;
      o_sram_dq_out <= w_wdata_nxt;
      o_sram_ce_n   <= (w_state_nxt == S_IDLE);
      o_sram_oe_n   <= (w_state_nxt != S_RD);
      o_sram_we_n   <= (w_state_nxt != S_WR_PULSE);
      o_sram_ub_n   <= (w_state_nxt == S_IDLE) | ~w_be_nxt[1];
      o_sram_lb_n   <= (w_state_nxt == S_IDLE) | ~w_be_nxt[0];
      o_sram_dq_oe  <= (w_state_nxt inside {S_WR_SETUP, S_WR_PULSE, S_WR_HOLD});
    end
  end
endmodule

// File: tb/tb_sram_access_seq.sv
// tb_sram_access_seq: randomized and directed checks of sram_access_seq against a transaction schedule model
module tb_sram_access_seq;
  localparam int AW = 20, RW = 2, WW = 2;
  logic clk = 0, rst_n = 0, rd = 0, wr = 0;
  logic [AW-1:0] addr = '0;
  logic [15:0] wdata = '0, dq_in = '0;
  logic [1:0] be = '0;
  logic busy, done, dropped, ce_n, oe_n, we_n, ub_n, lb_n, dq_oe;
  logic [15:0] rdata, dq_out;
  logic [AW-1:0] sram_addr;
  int compared = 0, mismatched = 0;
  // model: each access is a schedule anchored at its accepting edge number
  int e = 0, free_at = -100, acc_a = 0;
  bit acc_wr = 0, m_drop = 0;
  logic [AW-1:0] m_addr = '0;
  logic [15:0] m_wdata = '0, m_rdata = '0;
  logic [1:0] m_be = '0;
  logic [60:0] act_vec;
  sram_access_seq #(.ADDR_W(AW), .READ_WAIT(RW), .WRITE_WAIT(WW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_rd_req(rd), .i_wr_req(wr), .i_addr(addr),
    .i_wdata(wdata), .i_byte_en(be), .o_busy(busy), .o_done(done), .o_rdata(rdata),
    .o_dropped(dropped), .o_sram_addr(sram_addr), .o_sram_ce_n(ce_n), .o_sram_oe_n(oe_n),
    .o_sram_we_n(we_n), .o_sram_ub_n(ub_n), .o_sram_lb_n(lb_n), .o_sram_dq_out(dq_out),
    .o_sram_dq_oe(dq_oe), .i_sram_dq_in(dq_in)
  );
  always #5 clk = ~clk;
  assign act_vec = {busy, done, dropped, ce_n, oe_n, we_n, ub_n, lb_n, dq_oe, sram_addr, dq_out, rdata};
  function automatic logic [60:0] expv();
    int k = e - acc_a;
    bit bz = (e < free_at);
    bit wp = acc_wr && k >= 1 && k <= WW;
    return {bz, e == free_at, m_drop, !bz, !(bz && !acc_wr), !(bz && wp),
            !(bz && m_be[1]), !(bz && m_be[0]), bz && acc_wr, m_addr, m_wdata, m_rdata};
  endfunction
  task automatic model_reset();
    free_at = -100; acc_wr = 0; m_drop = 0; m_addr = '0; m_wdata = '0; m_rdata = '0; m_be = '0;
  endtask
  task automatic step(input logic r, input logic w, input logic [AW-1:0] a, input logic [15:0] d,
                      input logic [1:0] b, input logic [15:0] q);
    rd = r; wr = w; addr = a; wdata = d; be = b; dq_in = q;
    @(posedge clk);
    e++;
    m_drop = (r || w) && e <= free_at;
    if ((r || w) && e > free_at) begin
      acc_wr = w; acc_a = e; free_at = e + (w ? WW + 2 : RW);
      m_addr = a; m_wdata = d; m_be = b;
    end else if (!acc_wr && e == free_at) m_rdata = q;
    #1;
  endtask
  task automatic test_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    compared++;
    if (act_vec !== {3'b000, 5'b11111, 1'b0, 52'h0}) begin
      mismatched++; $display("FAIL reset_state: got %h want %h", act_vec, {3'b000, 5'b11111, 1'b0, 52'h0});
    end
    @(negedge clk); rst_n = 1;
  endtask
  task automatic test_read();
    int oe_low = 0, done_at = -1;
    step(1, 0, 20'h00123, 16'h5555, 2'b11, 16'hBEEF);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step(0, 0, 20'h0FFFF, 16'h0000, 2'b00, 16'hBEEF);
      compared++;
      if (act_vec !== expv()) begin mismatched++; $display("FAIL read_seq[%0d]: got %h want %h", i, act_vec, expv()); end
      if (!oe_n) oe_low++;
      if (done) done_at = i;
    end
    compared++; if (oe_low != RW) begin mismatched++; $display("FAIL read_oe_cycles: got %0d want %0d", oe_low, RW); end
    compared++; if (done_at != RW) begin mismatched++; $display("FAIL read_done_latency: got %0d want %0d", done_at, RW); end
    compared++; if (rdata !== 16'hBEEF) begin mismatched++; $display("FAIL read_data: got %h want beef", rdata); end
  endtask
  task automatic test_write();
    int we_low = 0, bad = 0, done_at = -1;
    step(0, 1, 20'h00040, 16'h1234, 2'b11, 16'($urandom));
    for (int i = 0; i < 6; i++) begin
      if (i > 0) step(0, 0, 20'($urandom), 16'($urandom), 2'b00, 16'($urandom));
      compared++;
      if (act_vec !== expv()) begin mismatched++; $display("FAIL write_seq[%0d]: got %h want %h", i, act_vec, expv()); end
      if (!we_n) we_low++;
      if ((!we_n && !dq_oe) || (!oe_n && dq_oe)) bad++;
      if (done) done_at = i;
    end
    compared++; if (we_low != WW) begin mismatched++; $display("FAIL write_we_cycles: got %0d want %0d", we_low, WW); end
    compared++; if (bad != 0) begin mismatched++; $display("FAIL write_bus_overlap: got %0d want 0", bad); end
    compared++; if (done_at != WW + 2) begin mismatched++; $display("FAIL write_done_latency: got %0d want %0d", done_at, WW + 2); end
  endtask
  task automatic test_collision();
    int oe_low = 0, we_low = 0, drops = 0;
    step(1, 1, 20'h00077, 16'hA5A5, 2'b11, 16'h0F0F);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) step(0, 0, 20'h0, 16'h0, 2'b00, 16'h0F0F);
      compared++;
      if (act_vec !== expv()) begin mismatched++; $display("FAIL collision_seq[%0d]: got %h want %h", i, act_vec, expv()); end
      if (!oe_n) oe_low++;
      if (!we_n) we_low++;
      if (dropped) drops++;
    end
    compared++;
    if ({oe_low, we_low, drops} != {32'd0, 32'(WW), 32'd0}) begin
      mismatched++; $display("FAIL collision_counts: got oe=%0d we=%0d drop=%0d want 0/%0d/0", oe_low, we_low, drops, WW);
    end
  endtask
  task automatic test_drop_during_read();
    int we_low = 0, drops = 0, done_at = -1;
    step(1, 0, 20'h00200, 16'h0000, 2'b11, 16'h1357);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step(0, i == 1, 20'h00999, 16'hDEAD, 2'b11, 16'h1357);
      compared++;
      if (act_vec !== expv()) begin mismatched++; $display("FAIL drop_seq[%0d]: got %h want %h", i, act_vec, expv()); end
      if (!we_n) we_low++;
      if (dropped) drops++;
      if (done) done_at = i;
    end
    compared++;
    if (drops != 1 || we_low != 0 || done_at != RW || rdata !== 16'h1357) begin
      mismatched++; $display("FAIL drop_read: got drop=%0d we=%0d done@%0d rd=%h want 1/0/%0d/1357", drops, we_low, done_at, rdata, RW);
    end
  endtask
  task automatic test_back_to_back();
    int d1 = -1, d2 = -1, ndone = 0;
    for (int i = 0; i < 12; i++) begin
      step(0, i <= WW + 3, 20'(16'h0300 + i), 16'(16'h4000 + i), 2'b11, 16'h0);
      compared++;
      if (act_vec !== expv()) begin mismatched++; $display("FAIL b2b_seq[%0d]: got %h want %h", i, act_vec, expv()); end
      if (done) begin ndone++; if (d1 < 0) d1 = i; else d2 = i; end
    end
    compared++;
    if (ndone != 2 || d1 != WW + 2 || d2 - d1 - 1 != WW + 2) begin
      mismatched++; $display("FAIL b2b_done: got n=%0d d1=%0d d2=%0d want 2/%0d/%0d", ndone, d1, d2, WW + 2, 2 * WW + 5);
    end
  endtask
  task automatic test_byte_en_zero();
    int strobes = 0, ndone = 0;
    step(1, 0, 20'h00ABC, 16'h0, 2'b00, 16'h2468);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step(0, 0, 20'h0, 16'h0, 2'b11, 16'h2468);
      compared++;
      if (act_vec !== expv()) begin mismatched++; $display("FAIL be0_seq[%0d]: got %h want %h", i, act_vec, expv()); end
      if (!ub_n || !lb_n) strobes++;
      if (done) ndone++;
    end
    compared++;
    if (strobes != 0 || ndone != 1) begin mismatched++; $display("FAIL be0_result: got strobes=%0d done=%0d want 0/1", strobes, ndone); end
  endtask
  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, 20'($urandom), 16'($urandom),
           2'($urandom), 16'($urandom));
      compared++;
      if (act_vec !== expv()) begin mismatched++; $display("FAIL random[%0d]: got %h want %h", i, act_vec, expv()); end
    end
  endtask
  task automatic test_reset_mid_write();
    step(0, 1, 20'h00555, 16'hCAFE, 2'b11, 16'h0);
    step(0, 0, 20'h0, 16'h0, 2'b00, 16'h0);
    step(0, 0, 20'h0, 16'h0, 2'b00, 16'h0);
    compared++;
    if (we_n !== 1'b0) begin mismatched++; $display("FAIL midrst_pre: got we_n=%b want 0", we_n); end
    #2 rst_n = 0;
    #1;
    compared++;
    if ({we_n, ce_n, dq_oe, done} !== 4'b1100) begin
      mismatched++; $display("FAIL midrst_release: got we/ce/oe/done=%b want 1100", {we_n, ce_n, dq_oe, done});
    end
    model_reset();
    @(negedge clk); rst_n = 1;
    for (int i = 0; i < 7; i++) begin
      step(i == 2, 0, 20'h00321, 16'h0, 2'b01, 16'h9ABC);
      compared++;
      if (act_vec !== expv()) begin mismatched++; $display("FAIL midrst_after[%0d]: got %h want %h", i, act_vec, expv()); end
    end
    compared++;
    if (rdata !== 16'h9ABC) begin mismatched++; $display("FAIL midrst_read: got %h want 9abc", rdata); end
  endtask
  initial begin
    test_reset();
    test_read();
    test_write();
    test_collision();
    test_drop_during_read();
    test_back_to_back();
    test_byte_en_zero();
    test_random();
    test_reset_mid_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
